// File: rtl/enemy_motion_ctrl_pkg.sv
// Shared enemy definitions: phase encoding and default lane geometry,
// common to the enemy controller, the game FSM and the VGA draw path.
package enemy_pkg;

   typedef enum logic [2:0] {
      PH_MOVE    = 3'd0,
      PH_WINDUP  = 3'd1,
      PH_STRIKE  = 3'd2,
      PH_RECOVER = 3'd3,
      PH_STUN    = 3'd4
   } phase_e;

   localparam int DEF_NUM_LANES = 3;
   localparam int DEF_LANE_X0   = 20;
   localparam int DEF_LANE_STEP = 40;
   localparam int DEF_X_W       = 8;

   // Pixel x of a lane centre; callers truncate to their x width.
   function automatic int lane_x(input int x0, input int step, input int lane);
      return x0 + lane * step;
   endfunction

endpackage

// File: rtl/enemy_motion_ctrl_if.sv
// Enemy controller bus: game-side controls in, position/phase status out.
interface enemy_motion_ctrl_if #(
   parameter int LANE_W = 2,
   parameter int X_W    = 8
);
   logic              enable;
   logic [1:0]        speed;
   logic [LANE_W-1:0] lane_req;
   logic              lane_req_valid;
   logic              attack_en;
   logic              player_block;
   logic [X_W-1:0]    x_out;
   logic [LANE_W-1:0] lane_cur;
   logic              move;
   logic              strike;
   logic [2:0]        phase;
   logic              stunned;

   modport master (
      output enable, speed, lane_req, lane_req_valid, attack_en, player_block,
      input  x_out, lane_cur, move, strike, phase, stunned
   );

   modport slave (
      input  enable, speed, lane_req, lane_req_valid, attack_en, player_block,
      output x_out, lane_cur, move, strike, phase, stunned
   );
endinterface

// File: rtl/enemy_motion_ctrl_tick_divider.sv
// Programmable tick divider: down-counter that pulses tick at terminal
// count zero and reloads, giving a period of reload+1 enabled cycles.
module tick_divider #(
   parameter int TICK_W    = 28,
   parameter int RESET_VAL = 99_999_999
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              enable,
   input  logic [TICK_W-1:0] reload,
   output logic              tick
);
   logic [TICK_W-1:0] cnt_q, cnt_d;

   // Count down while enabled; reload is sampled only at terminal count.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (enable) begin
         if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = reload;
         end else begin
            cnt_d = cnt_q - TICK_W'(1);
         end
      end
   end

   // Counter register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) cnt_q <= TICK_W'(RESET_VAL);
      else         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/enemy_motion_ctrl.sv
// Enemy lane motion and attack sequencer, paced by tick_divider.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   PH_MOVE    | step toward target lane each tick, count to attack
//   PH_WINDUP  | hold position WINDUP_TICKS ticks
//   PH_STRIKE  | one tick; player_block sampled here
//   PH_RECOVER | RECOVER_TICKS ticks after an unblocked strike
//   PH_STUN    | STUN_TICKS ticks after a blocked strike
module enemy_motion_ctrl
   import enemy_pkg::*;
#(
   parameter int NUM_LANES        = DEF_NUM_LANES,
   parameter int LANE_X0          = DEF_LANE_X0,
   parameter int LANE_STEP        = DEF_LANE_STEP,
   parameter int X_W              = DEF_X_W,
   parameter int TICK_W           = 28,
   parameter int BASE_DIV         = 99_999_999,
   parameter int MOVES_PER_ATTACK = 4,
   parameter int WINDUP_TICKS     = 2,
   parameter int RECOVER_TICKS    = 2,
   parameter int STUN_TICKS       = 4
) (
   input logic                clock,
   input logic                resetn,
   enemy_motion_ctrl_if.slave bus
);
   localparam int LANE_W  = ($clog2(NUM_LANES) < 1) ? 1 : $clog2(NUM_LANES);
   localparam int MC_W    = ($clog2(MOVES_PER_ATTACK) < 1) ? 1 : $clog2(MOVES_PER_ATTACK);
   localparam int PH_MAX0 = (WINDUP_TICKS > RECOVER_TICKS) ? WINDUP_TICKS : RECOVER_TICKS;
   localparam int PH_MAX  = (PH_MAX0 > STUN_TICKS) ? PH_MAX0 : STUN_TICKS;
   localparam int PC_W    = ($clog2(PH_MAX) < 1) ? 1 : $clog2(PH_MAX);
   localparam logic [MC_W-1:0] MC_LAST = MC_W'(MOVES_PER_ATTACK - 1);

   logic              tick;
   logic [TICK_W-1:0] reload;

   phase_e            phase_q, phase_d;
   logic [LANE_W-1:0] lane_q, lane_d, target_q, target_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [MC_W-1:0]   move_cnt_q, move_cnt_d;
   logic [PC_W-1:0]   ph_cnt_q, ph_cnt_d;
   logic              move_q, move_d, strike_q, strike_d, stunned_q, stunned_d;

   assign reload = TICK_W'(BASE_DIV) >> bus.speed;

   tick_divider #(
      .TICK_W    (TICK_W),
      .RESET_VAL (BASE_DIV)
   ) u_tick_divider (
      .clock  (clock),
      .resetn (resetn),
      .enable (bus.enable),
      .reload (reload),
      .tick   (tick)
   );

   // Next-state: target latch runs every cycle, FSM and lane advance on tick.
   always_comb begin
      target_d   = target_q;
      phase_d    = phase_q;
      lane_d     = lane_q;
      move_cnt_d = move_cnt_q;
      ph_cnt_d   = ph_cnt_q;
      move_d     = 1'b0;
      strike_d   = 1'b0;

      if (bus.lane_req_valid && (32'(bus.lane_req) < NUM_LANES))
         target_d = bus.lane_req;

      if (tick) begin
         unique case (phase_q)
            PH_MOVE: begin
               if (target_q > lane_q) begin
                  lane_d = lane_q + LANE_W'(1);
                  move_d = 1'b1;
               end else if (target_q < lane_q) begin
                  lane_d = lane_q - LANE_W'(1);
                  move_d = 1'b1;
               end
               // Counter parks at MC_LAST until attacks are permitted.
               if (move_cnt_q == MC_LAST) begin
                  if (bus.attack_en) begin
                     move_cnt_d = '0;
                     phase_d    = PH_WINDUP;
                     ph_cnt_d   = PC_W'(WINDUP_TICKS - 1);
                  end
               end else begin
                  move_cnt_d = move_cnt_q + MC_W'(1);
               end
            end
            PH_WINDUP: begin
               if (ph_cnt_q == '0) begin
                  phase_d  = PH_STRIKE;
                  strike_d = 1'b1;
               end else begin
                  ph_cnt_d = ph_cnt_q - PC_W'(1);
               end
            end
            PH_STRIKE: begin
               if (bus.player_block) begin
                  phase_d  = PH_STUN;
                  ph_cnt_d = PC_W'(STUN_TICKS - 1);
               end else begin
                  phase_d  = PH_RECOVER;
                  ph_cnt_d = PC_W'(RECOVER_TICKS - 1);
               end
            end
            PH_RECOVER, PH_STUN: begin
               if (ph_cnt_q == '0) phase_d  = PH_MOVE;
               else                ph_cnt_d = ph_cnt_q - PC_W'(1);
            end
            default: phase_d = PH_MOVE;
         endcase
      end

      x_d       = X_W'(lane_x(LANE_X0, LANE_STEP, 32'(lane_d)));
      stunned_d = (phase_d == PH_STUN);
   end

   // State and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         phase_q    <= PH_MOVE;
         lane_q     <= '0;
         target_q   <= '0;
         x_q        <= X_W'(LANE_X0);
         move_cnt_q <= '0;
         ph_cnt_q   <= '0;
         move_q     <= 1'b0;
         strike_q   <= 1'b0;
         stunned_q  <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         lane_q     <= lane_d;
         target_q   <= target_d;
         x_q        <= x_d;
         move_cnt_q <= move_cnt_d;
         ph_cnt_q   <= ph_cnt_d;
         move_q     <= move_d;
         strike_q   <= strike_d;
         stunned_q  <= stunned_d;
      end
   end

   assign bus.x_out    = x_q;
   assign bus.lane_cur = lane_q;
   assign bus.move     = move_q;
   assign bus.strike   = strike_q;
   assign bus.phase    = phase_q;
   assign bus.stunned  = stunned_q;
endmodule

// File: tb/tb_enemy_motion_ctrl.sv
// Bench for enemy_motion_ctrl (BASE_DIV=3): directed scenarios followed by
// random traffic, all outputs compared each cycle to a tick-level model.
module tb_enemy_motion_ctrl;
   localparam int LANES = 3;
   localparam int X0    = 20;
   localparam int STEP  = 40;
   localparam int MPA   = 4;
   localparam int WIND  = 2;
   localparam int REC   = 2;
   localparam int STUN  = 4;
   localparam int BDIV  = 3;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   always #5 clock = ~clock;

   enemy_motion_ctrl_if #(.LANE_W(2), .X_W(8)) bus ();

   enemy_motion_ctrl #(.BASE_DIV(BDIV)) u_dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: divider count, phase id, lane, target, MOVE ticks since
   // last attack (capped), ticks remaining in a timed phase, pulses.
   int m_cnt, m_phase, m_lane, m_target, m_moves, m_left, m_move, m_strike;

   task automatic model_reset();
      m_cnt = BDIV; m_phase = 0; m_lane = 0; m_target = 0;
      m_moves = 0; m_left = 0; m_move = 0; m_strike = 0;
   endtask

   task automatic model_edge();
      bit tk;
      if (!resetn) begin
         model_reset();
         return;
      end
      m_move = 0; m_strike = 0; tk = 1'b0;
      if (bus.enable) begin
         if (m_cnt == 0) begin
            tk = 1'b1;
            m_cnt = BDIV >> bus.speed;
         end else begin
            m_cnt = m_cnt - 1;
         end
      end
      if (tk) begin
         case (m_phase)
            0: begin
               if (m_target != m_lane) begin
                  m_lane = (m_target > m_lane) ? m_lane + 1 : m_lane - 1;
                  m_move = 1;
               end
               m_moves = m_moves + 1;
               if (m_moves >= MPA) begin
                  if (bus.attack_en) begin
                     m_moves = 0; m_phase = 1; m_left = WIND;
                  end else begin
                     m_moves = MPA;
                  end
               end
            end
            1: begin
               m_left = m_left - 1;
               if (m_left == 0) begin m_phase = 2; m_strike = 1; end
            end
            2: begin
               if (bus.player_block) begin m_phase = 4; m_left = STUN; end
               else begin m_phase = 3; m_left = REC; end
            end
            default: begin
               m_left = m_left - 1;
               if (m_left == 0) m_phase = 0;
            end
         endcase
      end
      if (bus.lane_req_valid && (int'(bus.lane_req) < LANES)) m_target = int'(bus.lane_req);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("tick",     32'(u_dut.tick), 32'((resetn && bus.enable && m_cnt == 0) ? 1 : 0));
      chk("x_out",    32'(bus.x_out), 32'(X0 + STEP * m_lane));
      chk("lane_cur", 32'(bus.lane_cur), 32'(m_lane));
      chk("move",     32'(bus.move), 32'(m_move));
      chk("strike",   32'(bus.strike), 32'(m_strike));
      chk("phase",    32'(bus.phase), 32'(m_phase));
      chk("stunned",  32'(bus.stunned), 32'((m_phase == 4) ? 1 : 0));
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic wait_phase(input int p, input int budget);
      for (int i = 0; i < budget && int'(bus.phase) != p; i++) step();
      chk("wait_phase", 32'(bus.phase), 32'(p));
   endtask

   // Asynchronous reset between edges, checked before any clock edge.
   task automatic async_reset_check();
      #2 resetn = 1'b0;
      #1;
      chk("arst_phase",   32'(bus.phase), 32'(0));
      chk("arst_x",       32'(bus.x_out), 32'(X0));
      chk("arst_lane",    32'(bus.lane_cur), 32'(0));
      chk("arst_move",    32'(bus.move), 32'(0));
      chk("arst_strike",  32'(bus.strike), 32'(0));
      chk("arst_stunned", 32'(bus.stunned), 32'(0));
      model_reset();
      step();
      resetn = 1'b1;
   endtask

   initial begin
      bus.enable = 1'b1; bus.speed = 2'd0; bus.lane_req = 2'd0;
      bus.lane_req_valid = 1'b0; bus.attack_en = 1'b0; bus.player_block = 1'b0;
      model_reset();
      repeat (3) step();
      resetn = 1'b1;

      // Divider pace at speed 0 then speed 1.
      repeat (12) step();
      bus.speed = 2'd1;
      repeat (10) step();

      // Lane request to 2, then an out-of-range request.
      bus.lane_req = 2'd2; bus.lane_req_valid = 1'b1; step(); bus.lane_req_valid = 1'b0;
      repeat (7) step();
      chk("t2_lane", 32'(bus.lane_cur), 32'(2));
      chk("t2_x",    32'(bus.x_out), 32'(100));
      bus.lane_req = 2'd3; bus.lane_req_valid = 1'b1; step(); bus.lane_req_valid = 1'b0;
      repeat (4) step();
      chk("t2_ignore", 32'(bus.lane_cur), 32'(2));

      // Attack cycle from reset: 0,1,2,3,0.
      bus.speed = 2'd0; bus.attack_en = 1'b1;
      async_reset_check();
      wait_phase(1, 40);
      wait_phase(2, 40);
      wait_phase(3, 40);
      wait_phase(0, 40);

      // Blocked strike into stun, then a block held during MOVE only.
      wait_phase(1, 80);
      wait_phase(2, 40);
      bus.player_block = 1'b1;
      wait_phase(4, 20);
      bus.player_block = 1'b0;
      wait_phase(0, 40);
      bus.player_block = 1'b1;
      repeat (8) step();
      bus.player_block = 1'b0;

      // Request latched during WINDUP applies only back in MOVE.
      wait_phase(1, 80);
      bus.lane_req = 2'd1; bus.lane_req_valid = 1'b1; step(); bus.lane_req_valid = 1'b0;
      wait_phase(3, 40);
      wait_phase(0, 40);
      chk("t5_hold", 32'(bus.lane_cur), 32'(0));
      repeat (5) step();
      chk("t5_step", 32'(bus.lane_cur), 32'(1));

      // Freeze mid-RECOVER, then reset mid-STUN.
      wait_phase(1, 80);
      wait_phase(3, 40);
      bus.enable = 1'b0;
      repeat (20) step();
      bus.enable = 1'b1;
      wait_phase(0, 40);
      wait_phase(2, 100);
      bus.player_block = 1'b1;
      wait_phase(4, 20);
      bus.player_block = 1'b0;
      repeat (5) step();
      async_reset_check();

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         bus.enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) bus.speed = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) bus.attack_en = ~bus.attack_en;
         bus.player_block   = 1'($urandom_range(0, 1));
         bus.lane_req       = 2'($urandom_range(0, 3));
         bus.lane_req_valid = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/enemy_motion_ctrl.md
# enemy_motion_ctrl

Parametrised enemy controller for the Punch-Out game datapath: drives the enemy's x coordinate across N lanes and sequences a windup/strike/recover attack cycle. It replaces the fixed 3-lane, 2-speed enemy datapath. A programmable tick divider sets the pace, and every tick advances either one lane step or one attack phase. It sits between the game FSM, which issues lane requests and the attack enable, and the VGA draw path, which consumes `x_out`.

## Interface
- `NUM_LANES`, 3: lane count, 2..16.
- `LANE_X0`, 20: x pixel of lane 0.
- `LANE_STEP`, 40: x pixel spacing between adjacent lanes.
- `X_W`, 8: x output width. Must satisfy LANE_X0+(NUM_LANES-1)*LANE_STEP < 2^X_W.
- `TICK_W`, 28: divider counter width.
- `BASE_DIV`, 99_999_999: reload value at speed 0.
- `MOVES_PER_ATTACK`, 4: MOVE-state ticks between attacks, ≥1.
- `WINDUP_TICKS`, 2; `RECOVER_TICKS`, 2; `STUN_TICKS`, 4: phase lengths in ticks, each ≥1.
- `LANE_W`: derived, $clog2(NUM_LANES), min 1.

Ports:
- `clock` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, the divider and FSM freeze.
- `speed` in 2: speed level. Reload = BASE_DIV >> speed.
- `lane_req` in LANE_W: requested target lane.
- `lane_req_valid` in 1: one-cycle strobe that latches `lane_req`.
- `attack_en` in 1: permits attacks.
- `player_block` in 1: player guard, sampled on the STRIKE tick.
- `x_out` out X_W: current enemy x pixel.
- `lane_cur` out LANE_W: current lane.
- `move` out 1: one-cycle pulse when the lane changes.
- `strike` out 1: one-cycle pulse when STRIKE is entered.
- `phase` out 3: FSM state encoding.
- `stunned` out 1: high while in STUN.

## Operation
FSM states:
- MOVE (0). On each tick:
  - If target ≠ lane_cur, step lane_cur one lane toward target and pulse `move`.
  - Increment `move_cnt` regardless of whether the lane changed.
  - If move_cnt reaches MOVES_PER_ATTACK−1 and attack_en=1, clear move_cnt and go to WINDUP.
  - If the threshold is reached with attack_en=0, move_cnt saturates at MOVES_PER_ATTACK−1. WINDUP is entered on the first tick where attack_en=1.
- WINDUP (1): hold position for WINDUP_TICKS ticks, then go to STRIKE. `strike` pulses on entry.
- STRIKE (2): lasts one tick.
  - If `player_block`=1 on that tick, go to STUN.
  - Otherwise go to RECOVER.
- RECOVER (3): lasts RECOVER_TICKS ticks, then go to MOVE.
- STUN (4): lasts STUN_TICKS ticks, then go to MOVE. `stunned`=1 throughout.

Lane target:
- `lane_req_valid`=1 with lane_req < NUM_LANES loads the target register in any state. If several requests arrive, the last one wins.
- Requests with lane_req ≥ NUM_LANES are ignored.
- The lane moves only in MOVE state. Requests latched during an attack or stun apply after the return to MOVE.
- Lane never wraps: it saturates at 0 and at NUM_LANES−1.

Position arithmetic:
- x_out = LANE_X0 + lane_cur*LANE_STEP, computed at X_W width and registered.
- Use a constant-multiply or an accumulator updated by ±LANE_STEP. Either way, x_out must equal the formula every cycle.

Enable:
- `enable`=0 freezes the counter, FSM, and phase counters.
- Lane requests are still latched.
- No pulses are emitted while disabled.

## Timing
Reset values (asynchronous on resetn low):
- counter = BASE_DIV
- phase = MOVE
- lane_cur = 0, target = 0
- x_out = LANE_X0
- move = strike = stunned = 0
- move_cnt = 0, phase counters = 0

Divider:
- Decrements each enabled cycle.
- At 0 it asserts an internal `tick` for one cycle and reloads with BASE_DIV>>speed.
- Tick period is (BASE_DIV>>speed)+1 cycles.
- A speed change takes effect at the next reload. The counter in flight is not truncated.

Latency:
- State, lane_cur, x_out, move, strike, and phase all update on the clock edge where tick=1. They are visible the cycle after the tick, and move/strike are aligned with x_out.
- A lane request is usable by the first tick at least one cycle after the strobe.
- Reset mid-attack returns to MOVE at lane 0 with no `strike` pulse.

## Structure
- Shared package `enemy_pkg` holds the phase encoding constants (PH_MOVE..PH_STUN) and the default lane and x constants, shared with the game FSM and the draw path.
- Sub-module `tick_divider` (clock, resetn, enable, reload, tick) is instantiated once. It is reusable by the player datapath.
- Everything else lives in one FSM plus datapath in `enemy_motion_ctrl`.

## Test plan
Bench parameters: BASE_DIV=3, defaults otherwise.

1. Reset, hold enable=1, speed=0 → tick every 4 cycles. Then set speed=1 → after the current count finishes, tick every 2 cycles.
2. lane_req=2 strobe with attack_en=0 → move pulses on two consecutive ticks; x_out goes 20→60→100; third tick gives no move. lane_req=3 → ignored; lane_cur stays 2.
3. attack_en=1 from reset → 4th MOVE tick enters WINDUP; strike pulses 2 ticks later; RECOVER lasts 2 ticks; phase sequence 0,1,2,3,0.
4. player_block=1 held during the STRIKE tick → phase=4, stunned=1 for exactly 4 ticks, then MOVE. Block outside STRIKE → no effect.
5. lane_req=1 issued during WINDUP → lane_cur unchanged until MOVE, then steps on the first MOVE tick.
6. enable=0 for 20 cycles mid-RECOVER → no tick and no pulse; the phase count resumes exactly. resetn pulse mid-STUN → all outputs return to reset values asynchronously.
